// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for one shared combinational ALU.
// Each operation takes three cycles: grant/latch, execute/capture, respond.
module alu_arbiter #(
    parameter logic RR_INIT = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  req,
    input  logic [1:0]  op0,
    input  logic [1:0]  op1,
    input  logic [31:0] a0,
    input  logic [31:0] b0,
    input  logic [31:0] a1,
    input  logic [31:0] b1,
    output logic [1:0]  gnt,
    output logic [1:0]  done,
    output logic [31:0] rsp_result,
    output logic        rsp_zero,
    output logic [31:0] alu_num1,
    output logic [31:0] alu_num2,
    output logic [1:0]  alu_op,
    input  logic [31:0] alu_result,
    input  logic        alu_zero,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    state_t state, state_next;
    logic   ptr;
    logic   owner;
    logic   winner;

    // The pointer only expresses a preference, so a lone requester never waits on it.
    always_comb begin
        state_next = state;
        gnt        = '0;
        done       = '0;
        winner     = req[ptr] ? ptr : ~ptr;
        case (state)
            IDLE: begin
                if (req != 2'b00) begin
                    gnt[winner] = 1'b1;
                    state_next  = EXEC;
                end
            end
            EXEC: state_next = RESP;
            RESP: begin
                done[owner] = 1'b1;
                state_next  = IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (reset) begin
            gnt  = '0;
            done = '0;
        end
    end

    assign busy = (state != IDLE);

    // The ALU operand/opcode outputs are the latch registers themselves, so they hold between operations.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            ptr        <= RR_INIT;
            owner      <= 1'b0;
            alu_num1   <= '0;
            alu_num2   <= '0;
            alu_op     <= '0;
            rsp_result <= '0;
            rsp_zero   <= 1'b0;
        end else begin
            state <= state_next;
            if (state == IDLE && req != 2'b00) begin
                owner    <= winner;
                alu_op   <= winner ? op1 : op0;
                alu_num1 <= winner ? a1 : a0;
                alu_num2 <= winner ? b1 : b0;
            end
            if (state == EXEC) begin
                rsp_result <= alu_result;
                rsp_zero   <= alu_zero;
            end
            if (state == RESP) begin
                ptr <= ~owner;
            end
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter with a behavioural shared ALU and a response scoreboard.
module tb_alu_arbiter;

    logic        clk;
    logic        reset;
    logic [1:0]  req;
    logic [1:0]  op0, op1;
    logic [31:0] a0, b0, a1, b1;
    logic [1:0]  gnt, done;
    logic [31:0] rsp_result;
    logic        rsp_zero;
    logic [31:0] alu_num1, alu_num2;
    logic [1:0]  alu_op;
    logic [31:0] alu_result;
    logic        alu_zero;
    logic        busy;

    typedef struct {
        logic [1:0]  d;
        logic [31:0] r;
        logic        z;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   total = 0;
    int   bad   = 0;

    alu_arbiter #(.RR_INIT(1'b0)) dut (
        .clk(clk), .reset(reset), .req(req),
        .op0(op0), .op1(op1), .a0(a0), .b0(b0), .a1(a1), .b1(b1),
        .gnt(gnt), .done(done), .rsp_result(rsp_result), .rsp_zero(rsp_zero),
        .alu_num1(alu_num1), .alu_num2(alu_num2), .alu_op(alu_op),
        .alu_result(alu_result), .alu_zero(alu_zero), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference ALU: opcode 11 returns a fixed marker, the flag means operand equality.
    always_comb begin
        case (alu_op)
            2'b00:   alu_result = alu_num1 + alu_num2;
            2'b01:   alu_result = alu_num1 - alu_num2;
            2'b10:   alu_result = alu_num1 | alu_num2;
            default: alu_result = 32'h12345678;
        endcase
        alu_zero = (alu_num1 == alu_num2);
    end

    task automatic test_reset();
        reset = 1'b1;
        req   = 2'b11;
        repeat (2) @(negedge clk);
        #1;
        total++;
        if ({gnt, done, busy, rsp_zero} !== 6'b0 || rsp_result !== 32'd0 || alu_num1 !== 32'd0 ||
            alu_num2 !== 32'd0 || alu_op !== 2'b00) begin
            bad++;
            $display("[TB] FAIL reset_state: got gnt=%b done=%b busy=%b res=%h z=%b n1=%h n2=%h op=%b, expected all zero",
                     gnt, done, busy, rsp_result, rsp_zero, alu_num1, alu_num2, alu_op);
        end
        @(negedge clk);
        reset = 1'b0;
        req   = 2'b00;
    endtask

    task automatic test_single();
        @(negedge clk);
        req = 2'b01; op0 = 2'b00; a0 = 32'd5; b0 = 32'd7;
        #1;
        total++;
        if (gnt !== 2'b01) begin bad++; $display("[TB] FAIL single_gnt: got %b expected 01", gnt); end
        sb.push_back('{d: 2'b01, r: 32'd12, z: 1'b0});
        @(negedge clk);
        req = 2'b00;
        #1;
        total++;
        if ({busy, gnt, done} !== 5'b10000) begin
            bad++; $display("[TB] FAIL single_exec: got busy=%b gnt=%b done=%b expected 1/00/00", busy, gnt, done);
        end
        @(negedge clk);
        #1;
        e = sb.pop_front();
        total++;
        if (busy !== 1'b1 || {done, rsp_result, rsp_zero} !== {e.d, e.r, e.z}) begin
            bad++; $display("[TB] FAIL single_done: got busy=%b done=%b res=%h z=%b expected 1 %b %h %b",
                            busy, done, rsp_result, rsp_zero, e.d, e.r, e.z);
        end
        @(negedge clk);
        #1;
        total++;
        if (busy !== 1'b0 || done !== 2'b00) begin
            bad++; $display("[TB] FAIL single_idle: got busy=%b done=%b expected 0/00", busy, done);
        end
    endtask

    task automatic test_contention();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        req = 2'b11;
        op0 = 2'b01; a0 = 32'd10; b0 = 32'd10;
        op1 = 2'b10; a1 = 32'hF0; b1 = 32'h0F;
        #1;
        total++;
        if (gnt !== 2'b01) begin bad++; $display("[TB] FAIL cont_gnt0: got %b expected 01", gnt); end
        sb.push_back('{d: 2'b01, r: 32'd0, z: 1'b1});
        @(negedge clk);
        req = 2'b10;
        #1;
        total++;
        if ({gnt, done} !== 4'b0000) begin
            bad++; $display("[TB] FAIL cont_exec: got gnt=%b done=%b expected 00/00", gnt, done);
        end
        @(negedge clk);
        #1;
        e = sb.pop_front();
        total++;
        if (gnt !== 2'b00 || {done, rsp_result, rsp_zero} !== {e.d, e.r, e.z}) begin
            bad++; $display("[TB] FAIL cont_done0: got gnt=%b done=%b res=%h z=%b expected 00 %b %h %b",
                            gnt, done, rsp_result, rsp_zero, e.d, e.r, e.z);
        end
        @(negedge clk);
        #1;
        total++;
        if (gnt !== 2'b10) begin bad++; $display("[TB] FAIL cont_gnt1: got %b expected 10", gnt); end
        sb.push_back('{d: 2'b10, r: 32'hFF, z: 1'b0});
        @(negedge clk);
        req = 2'b00;
        @(negedge clk);
        #1;
        e = sb.pop_front();
        total++;
        if ({done, rsp_result, rsp_zero} !== {e.d, e.r, e.z}) begin
            bad++; $display("[TB] FAIL cont_done1: got done=%b res=%h z=%b expected %b %h %b",
                            done, rsp_result, rsp_zero, e.d, e.r, e.z);
        end
    endtask

    // Pointer is left at 0 here, so requester 1 alone must still be served every third cycle.
    task automatic test_lone_repeater();
        logic [1:0] exp_gnt;
        @(negedge clk);
        req = 2'b10; op1 = 2'b00; a1 = 32'd40; b1 = 32'd2;
        for (int c = 0; c < 9; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            exp_gnt = (c % 3 == 0) ? 2'b10 : 2'b00;
            total++;
            if (gnt !== exp_gnt) begin
                bad++; $display("[TB] FAIL lone_gnt c=%0d: got %b expected %b", c, gnt, exp_gnt);
            end
            if (exp_gnt != 2'b00) sb.push_back('{d: 2'b10, r: 32'd42, z: 1'b0});
            if (c % 3 == 2) begin
                e = sb.pop_front();
                total++;
                if ({done, rsp_result, rsp_zero} !== {e.d, e.r, e.z}) begin
                    bad++; $display("[TB] FAIL lone_done c=%0d: got done=%b res=%h z=%b expected %b %h %b",
                                    c, done, rsp_result, rsp_zero, e.d, e.r, e.z);
                end
            end
        end
        req = 2'b00;
    endtask

    task automatic test_wrap_undef();
        logic [1:0] exp_op;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            if (i == 0) begin
                req = 2'b01; op0 = 2'b00; a0 = 32'hFFFF_FFFF; b0 = 32'd1; exp_op = 2'b00;
                sb.push_back('{d: 2'b01, r: 32'd0, z: 1'b0});
            end else begin
                req = 2'b10; op1 = 2'b11; a1 = 32'd3; b1 = 32'd3; exp_op = 2'b11;
                sb.push_back('{d: 2'b10, r: 32'h12345678, z: 1'b1});
            end
            #1;
            total++;
            if (gnt !== req) begin bad++; $display("[TB] FAIL wrap_gnt i=%0d: got %b expected %b", i, gnt, req); end
            @(negedge clk);
            req = 2'b00;
            #1;
            total++;
            if (alu_op !== exp_op) begin bad++; $display("[TB] FAIL wrap_aluop i=%0d: got %b expected %b", i, alu_op, exp_op); end
            @(negedge clk);
            #1;
            e = sb.pop_front();
            total++;
            if ({done, rsp_result, rsp_zero} !== {e.d, e.r, e.z}) begin
                bad++; $display("[TB] FAIL wrap_done i=%0d: got done=%b res=%h z=%b expected %b %h %b",
                                i, done, rsp_result, rsp_zero, e.d, e.r, e.z);
            end
        end
        @(negedge clk);
        #1;
        total++;
        if (alu_op !== 2'b11 || alu_num1 !== 32'd3 || alu_num2 !== 32'd3 || rsp_result !== 32'h12345678) begin
            bad++; $display("[TB] FAIL hold_idle: got op=%b n1=%h n2=%h res=%h expected 11 3 3 12345678",
                            alu_op, alu_num1, alu_num2, rsp_result);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        req = 2'b01; op0 = 2'b10; a0 = 32'd1; b0 = 32'd2;
        sb.push_back('{d: 2'b01, r: 32'd3, z: 1'b0});
        @(negedge clk);
        req = 2'b00;
        @(negedge clk);
        #1;
        e = sb.pop_front();
        total++;
        if ({done, rsp_result, rsp_zero} !== {e.d, e.r, e.z}) begin
            bad++; $display("[TB] FAIL rstmid_pre: got done=%b res=%h z=%b expected %b %h %b",
                            done, rsp_result, rsp_zero, e.d, e.r, e.z);
        end
        @(negedge clk);
        req = 2'b11; op1 = 2'b00; a1 = 32'd9; b1 = 32'd9;
        #1;
        total++;
        if (gnt !== 2'b10) begin bad++; $display("[TB] FAIL rstmid_ptr_gnt: got %b expected 10", gnt); end
        @(negedge clk);
        req   = 2'b00;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        total++;
        if ({gnt, done, busy, rsp_zero} !== 6'b0 || rsp_result !== 32'd0 || alu_num1 !== 32'd0 ||
            alu_num2 !== 32'd0 || alu_op !== 2'b00) begin
            bad++; $display("[TB] FAIL rstmid_clear: got gnt=%b done=%b busy=%b res=%h z=%b n1=%h n2=%h op=%b expected all zero",
                            gnt, done, busy, rsp_result, rsp_zero, alu_num1, alu_num2, alu_op);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            total++;
            if (done !== 2'b00) begin bad++; $display("[TB] FAIL rstmid_nodone c=%0d: got %b expected 00", c, done); end
        end
        @(negedge clk);
        req = 2'b11; op0 = 2'b00; a0 = 32'd2; b0 = 32'd2;
        #1;
        total++;
        if (gnt !== 2'b01) begin bad++; $display("[TB] FAIL rstmid_regnt: got %b expected 01", gnt); end
        sb.push_back('{d: 2'b01, r: 32'd4, z: 1'b1});
        @(negedge clk);
        req = 2'b00;
        @(negedge clk);
        #1;
        e = sb.pop_front();
        total++;
        if ({done, rsp_result, rsp_zero} !== {e.d, e.r, e.z}) begin
            bad++; $display("[TB] FAIL rstmid_done: got done=%b res=%h z=%b expected %b %h %b",
                            done, rsp_result, rsp_zero, e.d, e.r, e.z);
        end
    endtask

    task automatic test_disturbance();
        @(negedge clk);
        req = 2'b01; op0 = 2'b00; a0 = 32'd100; b0 = 32'd23;
        op1 = 2'b10; a1 = 32'h0F00; b1 = 32'h00F0;
        #1;
        total++;
        if (gnt !== 2'b01) begin bad++; $display("[TB] FAIL dist_gnt: got %b expected 01", gnt); end
        sb.push_back('{d: 2'b01, r: 32'd123, z: 1'b0});
        @(negedge clk);
        req = 2'b10; op0 = 2'b01; a0 = 32'd7;
        #1;
        total++;
        if (gnt !== 2'b00 || alu_num1 !== 32'd100 || alu_op !== 2'b00) begin
            bad++; $display("[TB] FAIL dist_exec: got gnt=%b n1=%h op=%b expected 00 64 00", gnt, alu_num1, alu_op);
        end
        @(negedge clk);
        #1;
        e = sb.pop_front();
        total++;
        if (gnt !== 2'b00 || {done, rsp_result, rsp_zero} !== {e.d, e.r, e.z}) begin
            bad++; $display("[TB] FAIL dist_done: got gnt=%b done=%b res=%h z=%b expected 00 %b %h %b",
                            gnt, done, rsp_result, rsp_zero, e.d, e.r, e.z);
        end
        @(negedge clk);
        #1;
        total++;
        if (gnt !== 2'b10) begin bad++; $display("[TB] FAIL dist_late_req: got %b expected 10", gnt); end
        sb.push_back('{d: 2'b10, r: 32'h0FF0, z: 1'b0});
        @(negedge clk);
        req = 2'b00;
        @(negedge clk);
        #1;
        e = sb.pop_front();
        total++;
        if ({done, rsp_result, rsp_zero} !== {e.d, e.r, e.z}) begin
            bad++; $display("[TB] FAIL dist_done1: got done=%b res=%h z=%b expected %b %h %b",
                            done, rsp_result, rsp_zero, e.d, e.r, e.z);
        end
    endtask

    initial begin
        reset = 1'b1;
        req = 2'b00; op0 = 2'b00; op1 = 2'b00;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0;
        test_reset();
        test_single();
        test_contention();
        test_lone_repeater();
        test_wrap_undef();
        test_reset_mid();
        test_disturbance();
        total++;
        if (sb.size() != 0) begin bad++; $display("[TB] FAIL sb_empty: got %0d entries expected 0", sb.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: RR_INIT, default 1'b0, requester index holding priority after reset.
REQ-002 Ports, one per line (name  direction  width  meaning):
- clk  input  1  single clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- req  input  2  req[i] = requester i asks for one ALU operation; held until gnt[i] is sampled.
- op0 / op1  input  2 each  ALU opcode of requester 0 / 1 (00 ADD, 01 SUB, 10 OR, 11 undefined).
- a0 / b0, a1 / b1  input  32 each  operands of requester 0 / 1.
- gnt  output  2  one-hot, one-cycle pulse; operands of the granted requester are captured at this edge.
- done  output  2  one-hot, one-cycle pulse; rsp_result and rsp_zero are valid for the granted requester.
- rsp_result  output  32  captured ALU result.
- rsp_zero  output  1  captured ALU zero flag.
- alu_num1 / alu_num2  output  32 each  operands driven to the shared ALU.
- alu_op  output  2  opcode driven to the shared ALU.
- alu_result  input  32  ALU result (combinational from alu_num1/alu_num2/alu_op).
- alu_zero  input  1  ALU flag, which is 1 when num1 == num2.
- busy  output  1  1 whenever the state is not IDLE.

Function
REQ-003 FSM states: IDLE, EXEC, RESP.
REQ-004 IDLE, no req: stay in IDLE; gnt = 0.
REQ-005 IDLE, any req: gnt is combinational in the same cycle.
- Winner: the requester named by the priority pointer if it is requesting, otherwise the other requester.
- At the clock edge: latch the winner's op/a/b and the owner index, then go to EXEC.
REQ-006 EXEC:
- alu_num1/alu_num2/alu_op are driven from the latched values.
- At the end of the cycle: rsp_result <= alu_result and rsp_zero <= alu_zero, then go to RESP.
REQ-007 RESP:
- done[owner] = 1 for exactly one cycle.
- rsp_result/rsp_zero are stable.
- Pointer <= the index that was not granted.
- Next state is IDLE.
REQ-008 Latency and throughput:
- gnt in cycle T gives done in cycle T+2.
- Next grant no earlier than T+3; maximum throughput is one operation per 3 cycles.
REQ-009 gnt and done are never asserted in the same cycle; at most one bit of each is set.
REQ-010 Input changes outside the IDLE grant cycle are ignored:
- req, op, a and b changes during EXEC/RESP have no effect.
- A req still high in RESP is considered in the following IDLE cycle.
REQ-011 Opcode passes through unmodified. For op 11, rsp_result is whatever the ALU returns; no error is flagged.
REQ-012 Arithmetic and flags:
- Results are 32-bit and wrap modulo 2^32.
- No carry or overflow output.
- rsp_zero reflects operand equality, not a zero result.
REQ-013 Output hold:
- alu_num1/alu_num2/alu_op hold the last latched values in IDLE and RESP.
- rsp_result/rsp_zero hold until the next EXEC capture.
REQ-014 A lone requester is served every 3 cycles regardless of the pointer value.

Reset
REQ-015 Reset (synchronous, active-high) sets:
- state IDLE, pointer RR_INIT;
- gnt, done, rsp_result, rsp_zero, alu_num1, alu_num2, alu_op and busy all 0.
REQ-016 Reset overrides all inputs and has priority over every transition.
REQ-017 Reset in EXEC or RESP abandons the operation:
- no done is produced for it;
- the requester must re-request.

Verification
REQ-018 Single request: after reset, req=01, op0=00, a0=5, b0=7 at T.
- gnt=01 at T; done=01 at T+2; rsp_result=12; rsp_zero=0; busy high during T+1..T+2.
REQ-019 Contention: RR_INIT=0; req=11 at T; op0=01, a0=b0=10; op1=10, a1=0xF0, b1=0x0F.
- done=01 at T+2 with result 0, zero 1.
- gnt=10 at T+3; done=10 at T+5 with result 0xFF, zero 0.
REQ-020 Lone repeater: req1 held high continuously.
- gnt=10 at T, T+3, T+6; no gnt[0]; pointer does not stall the requester.
REQ-021 Wrap and undefined op:
- ADD 0xFFFFFFFF+1 gives rsp_result=0, rsp_zero=0.
- op=11 with any operands gives rsp_result=32'h12345678.
REQ-022 Reset mid-operation: reset asserted in the EXEC cycle.
- Next cycle: all outputs 0, no done.
- A new req=11 is granted to RR_INIT.
REQ-023 Input disturbance: a0/op0 changed during EXEC.
- rsp_result equals the result computed from the values latched at gnt.
